// File: rtl/branch_pkg.sv
// Shared types for the branch unit: FSM states and branch condition codes.
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_EQ     = 3'd1,
        COND_NE     = 3'd2,
        COND_LT     = 3'd3,
        COND_GE     = 3'd4,
        COND_CS     = 3'd5,
        COND_VS     = 3'd6,
        COND_NEVER  = 3'd7
    } cond_t;

    localparam int FLAGS_W   = 4;
    localparam int RETIRED_W = 16;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition decode over z/c/n/v.
// Latency 0; no flow control.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] cond,
    input  logic       z,
    input  logic       c,
    input  logic       n,
    input  logic       v,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cond_t'(cond))
            COND_ALWAYS: take = 1'b1;
            COND_EQ:     take = z;
            COND_NE:     take = ~z;
            COND_LT:     take = n;
            COND_GE:     take = ~n;
            COND_CS:     take = c;
            COND_VS:     take = v;
            COND_NEVER:  take = 1'b0;
            default:     take = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// PC sequencer with conditional branches, flag register, halt FSM and retire counter.
// One-cycle update per stall-free RUN cycle; stall freezes all architectural state.
module branch_unit
    import branch_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int START_PC = 0
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 halt_req,
    input  logic                 flag_we,
    input  logic                 z_in,
    input  logic                 c_in,
    input  logic                 n_in,
    input  logic                 v_in,
    input  logic                 br_valid,
    input  logic [2:0]           br_cond,
    input  logic                 br_rel,
    input  logic [PC_W-1:0]      br_target,
    output logic [PC_W-1:0]      pc,
    output logic [FLAGS_W-1:0]   flags,
    output logic                 running,
    output logic                 done,
    output logic [RETIRED_W-1:0] retired
);

    localparam logic [PC_W-1:0] W_START = PC_W'(START_PC);

    state_t                r_state;
    logic [PC_W-1:0]       r_pc;
    logic [FLAGS_W-1:0]    r_flags;
    logic [RETIRED_W-1:0]  r_retired;

    logic w_z, w_c, w_n, w_v, w_take;
    logic [PC_W-1:0] w_target;

    // Forward the ALU flags being written this cycle into the condition check.
    assign w_z = flag_we ? z_in : r_flags[3];
    assign w_c = flag_we ? c_in : r_flags[2];
    assign w_n = flag_we ? n_in : r_flags[1];
    assign w_v = flag_we ? v_in : r_flags[0];

    branch_cond_eval u_cond (
        .cond (br_cond),
        .z    (w_z),
        .c    (w_c),
        .n    (w_n),
        .v    (w_v),
        .take (w_take)
    );

    // A PC_W-bit add already gives the sign-extended offset modulo 2^PC_W.
    assign w_target = br_rel ? (r_pc + br_target) : br_target;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pc      <= W_START;
            r_flags   <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        r_state   <= RUN;
                        r_pc      <= W_START;
                        r_flags   <= '0;
                        r_retired <= '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (r_retired != {RETIRED_W{1'b1}})
                            r_retired <= r_retired + 1'b1;
                        if (flag_we)
                            r_flags <= {z_in, c_in, n_in, v_in};
                        if (halt_req)
                            r_state <= HALT;
                        else if (br_valid && w_take)
                            r_pc <= w_target;
                        else
                            r_pc <= r_pc + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign pc      = r_pc;
    assign flags   = r_flags;
    assign retired = r_retired;
    assign running = (r_state == RUN);
    assign done    = (r_state == HALT);

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed scenarios then random stimulus vs a behavioural model.
module tb_branch_unit;

    typedef struct {
        int pc;
        int flags;
        int running;
        int done;
        int retired;
    } exp_t;

    logic       CLK = 1'b0;
    logic       reset = 1'b0, start = 1'b0, stall = 1'b0, halt_req = 1'b0, flag_we = 1'b0;
    logic       z_in = 1'b0, c_in = 1'b0, n_in = 1'b0, v_in = 1'b0;
    logic       br_valid = 1'b0, br_rel = 1'b0;
    logic [2:0] br_cond = 3'd0;
    logic [9:0] br_target = 10'd0;
    logic [9:0] pc;
    logic [3:0] flags;
    logic       running, done;
    logic [15:0] retired;

    branch_unit #(.PC_W(10), .START_PC(0)) dut (
        .CLK(CLK), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
        .flag_we(flag_we), .z_in(z_in), .c_in(c_in), .n_in(n_in), .v_in(v_in),
        .br_valid(br_valid), .br_cond(br_cond), .br_rel(br_rel), .br_target(br_target),
        .pc(pc), .flags(flags), .running(running), .done(done), .retired(retired)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // Reference model: 0 idle, 1 run, 2 halted
    int m_mode = 0;
    int m_pc = 0;
    int m_z = 0, m_c = 0, m_n = 0, m_v = 0;
    int m_ret = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic bit cond_true(input int cond, input int z, input int c, input int n, input int v);
        case (cond)
            0: return 1;
            1: return z == 1;
            2: return z == 0;
            3: return n == 1;
            4: return n == 0;
            5: return c == 1;
            6: return v == 1;
            default: return 0;
        endcase
    endfunction

    task automatic model(input bit rst, st, stl, hr, fwe, input int fz, fc, fn, fv,
                         input bit bv, input int cond, input bit rel, input int tgt);
        int ez, ec, en, ev, off;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_ret = 0;
            m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        end else if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = 0; m_ret = 0;
                m_z = 0; m_c = 0; m_n = 0; m_v = 0;
            end
        end else if (!stl) begin
            ez = fwe ? fz : m_z; ec = fwe ? fc : m_c;
            en = fwe ? fn : m_n; ev = fwe ? fv : m_v;
            if (m_ret < 65535) m_ret = m_ret + 1;
            if (fwe) begin m_z = fz; m_c = fc; m_n = fn; m_v = fv; end
            if (hr) m_mode = 2;
            else if (bv && cond_true(cond, ez, ec, en, ev)) begin
                if (rel) begin
                    off = (tgt >= 512) ? tgt - 1024 : tgt;
                    m_pc = (m_pc + off + 1024) % 1024;
                end else begin
                    m_pc = tgt;
                end
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
    endtask

    task automatic step(input bit rst, st, stl, hr, fwe, input int fl,
                        input bit bv, input int cond, input bit rel, input int tgt);
        exp_t e;
        reset = rst; start = st; stall = stl; halt_req = hr; flag_we = fwe;
        z_in = fl[3]; c_in = fl[2]; n_in = fl[1]; v_in = fl[0];
        br_valid = bv; br_cond = cond[2:0]; br_rel = rel; br_target = tgt[9:0];
        model(rst, st, stl, hr, fwe, (fl >> 3) & 1, (fl >> 2) & 1, (fl >> 1) & 1, fl & 1,
              bv, cond, rel, tgt);
        e.pc = m_pc;
        e.flags = m_z * 8 + m_c * 4 + m_n * 2 + m_v;
        e.running = (m_mode == 1) ? 1 : 0;
        e.done = (m_mode == 2) ? 1 : 0;
        e.retired = m_ret;
        q.push_back(e);
        @(posedge CLK);
        #2;
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle that has a pending expectation is compared after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_pc", int'(pc), e.pc);
                chk("sb_flags", int'(flags), e.flags);
                chk("sb_running", int'(running), e.running);
                chk("sb_done", int'(done), e.done);
                chk("sb_retired", int'(retired), e.retired);
            end
        end
    end

    initial begin
        int rel_pc, stall_ret, wait_cnt;
        @(posedge CLK); #2;

        // Reset, then start and five sequential instructions
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_pc", int'(pc), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_done", int'(done), 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("start_pc", int'(pc), 0);
        chk("start_running", int'(running), 1);
        plain(5);
        chk("seq5_pc", int'(pc), 5);
        chk("seq5_retired", int'(retired), 5);

        // Forwarded zero flag makes EQ taken to absolute 0x120
        step(0, 0, 0, 0, 1, 8, 1, 1, 0, 'h120);
        chk("fwd_pc", int'(pc), 'h120);

        // Relative backward branch that wraps below zero
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h002);
        chk("to2_pc", int'(pc), 'h002);
        step(0, 0, 0, 0, 0, 0, 1, 0, 1, 'h3FC);
        rel_pc = int'(pc);
        chk("rel_pc", rel_pc, 'h3FE);
        plain(2);
        chk("wrap_pc", int'(pc), 'h000);

        // Stall with branch and halt pending must freeze everything
        stall_ret = int'(retired);
        chk("pre_stall_retired", stall_ret, 10);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, 15, 1, 0, 0, 'h155);
        chk("stall_pc", int'(pc), 0);
        chk("stall_retired", int'(retired), 10);
        chk("stall_running", int'(running), 1);

        // Halt wins over a simultaneous ALWAYS branch
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, 'h010);
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, 'h200);
        chk("halt_done", int'(done), 1);
        chk("halt_pc", int'(pc), 'h010);
        chk("halt_retired", int'(retired), 12);
        step(0, 0, 0, 0, 1, 15, 1, 0, 0, 'h300);
        chk("halt_ignores_pc", int'(pc), 'h010);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("restart_pc", int'(pc), 0);
        chk("restart_retired", int'(retired), 0);
        chk("restart_running", int'(running), 1);

        // Reset beats start while running with flags set and a branch pending
        step(0, 0, 0, 0, 1, 'hB, 0, 0, 0, 0);
        chk("flags_latched", int'(flags), 'hB);
        step(1, 1, 0, 0, 0, 0, 1, 0, 0, 'h0AA);
        chk("rst_start_running", int'(running), 0);
        chk("rst_start_pc", int'(pc), 0);
        chk("rst_start_flags", int'(flags), 0);

        // Randomised traffic checked only through the scoreboard
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 97) == 0, ($urandom % 6) == 0, ($urandom % 5) == 0,
                 ($urandom % 40) == 0, ($urandom % 3) == 0, int'($urandom % 16),
                 ($urandom % 2) == 1, int'($urandom % 8), ($urandom % 2) == 1,
                 int'($urandom % 1024));
        end

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            @(posedge CLK); #2;
            wait_cnt++;
        end
        chk("scoreboard_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, program counter width in bits.
REQ-002 SHALL have parameter START_PC, default 0, PC value loaded on reset and on start.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  leave IDLE/HALT and begin fetching at START_PC.
REQ-006 SHALL have port stall  input  1  hold PC and retire count this cycle.
REQ-007 SHALL have port halt_req  input  1  current instruction is a halt.
REQ-008 SHALL have port flag_we  input  1  latch ALU flags this cycle (compare/arith result).
REQ-009 SHALL have ports z_in, c_in, n_in, v_in  input  1 each  ALU zero/carry/negative/overflow.
REQ-010 SHALL have port br_valid  input  1  current instruction is a branch.
REQ-011 SHALL have port br_cond  input  3  condition code (see REQ-020).
REQ-012 SHALL have port br_rel  input  1  1 means relative target, 0 means absolute.
REQ-013 SHALL have port br_target  input  PC_W  absolute target, or a signed two's-complement offset when br_rel is 1.
REQ-014 SHALL have port pc  output  PC_W  address of the instruction being executed.
REQ-015 SHALL have port flags  output  4  registered {z,c,n,v}.
REQ-016 SHALL have port running  output  1  high only in RUN.
REQ-017 SHALL have port done  output  1  high only in HALT.
REQ-018 SHALL have port retired  output  16  count of instructions completed since start.

Function
REQ-019 SHALL implement FSM IDLE -> RUN on start; RUN -> HALT on halt_req with stall=0; HALT -> RUN on start; no other transitions except reset.
REQ-020 SHALL decode br_cond as 0 ALWAYS, 1 EQ(z), 2 NE(!z), 3 LT(n), 4 GE(!n), 5 CS(c), 6 VS(v), 7 NEVER.
REQ-021 SHALL, in RUN with stall=0 and br_valid=1 and condition true, load pc with br_target (absolute) or pc+br_target (relative, sign-extended, modulo 2^PC_W).
REQ-022 SHALL otherwise, in RUN with stall=0, advance pc to pc+1, wrapping from 2^PC_W-1 to 0.
REQ-023 SHALL evaluate the condition on the incoming z/c/n/v when flag_we and br_valid are asserted in the same cycle (forwarding); otherwise on the registered flags.
REQ-024 SHALL latch flags from z/c/n/v on flag_we in RUN with stall=0; flags hold otherwise.
REQ-025 SHALL increment retired by 1, saturating at 16'hFFFF, for each RUN cycle with stall=0, including the halt instruction.
REQ-026 SHALL, when stall=1, hold pc, flags, retired and state; halt_req and br_valid are ignored that cycle.
REQ-027 SHALL give halt_req priority over br_valid: pc holds at the halt instruction address.
REQ-028 SHALL, on start in IDLE or HALT, load pc=START_PC and clear retired and flags; start in RUN is ignored.
REQ-029 SHALL ignore flag_we, br_valid and halt_req outside RUN.
REQ-030 SHALL make every output a registered value or a direct decode of state; there is no combinational input-to-output path.

Reset
REQ-031 SHALL, on reset, set state IDLE, pc=START_PC, flags=0, retired=0, running=0, done=0.
REQ-032 SHALL give reset priority over all inputs, including start; reset mid-RUN abandons any pending branch.

Structure
REQ-033 SHALL put the br_cond encoding and the state enum (IDLE, RUN, HALT) in the shared package branch_pkg.
REQ-034 SHALL implement the condition evaluation as a combinational sub-module, branch_cond_eval (inputs: cond, z, c, n, v; output: take).

Verification
REQ-035 SHALL check: reset, then start -> pc=0, running=1; 5 stall-free cycles -> pc=5, retired=5.
REQ-036 SHALL check: flag_we with z_in=1 and br_valid, br_cond=EQ, br_rel=0, br_target=0x120 in the same cycle -> next pc=0x120 (forwarding).
REQ-037 SHALL check, relative wrap: at pc=0x002, br_rel=1, br_target=0x3FC (-4), ALWAYS -> pc=0x3FE; then 2 sequential cycles -> pc=0x000.
REQ-038 SHALL check: stall=1 for 3 cycles with br_valid=1 and halt_req=1 -> pc, retired and state unchanged.
REQ-039 SHALL check: halt_req and br_valid (ALWAYS) together at pc=0x010 -> done=1, pc=0x010; then start -> pc=0, retired=0.
REQ-040 SHALL check: reset asserted together with start in RUN -> IDLE, pc=0, flags=0.
